// File: rtl/simon_ctrl_gen.sv
// simon_ctrl_gen: Simon Says game controller.
// Sequences the start handshake, round growth, sequence playback, player
// checking, per-move timeout and the failure flash for an N-colour game.
// All outputs are Moore outputs decoded from the state register and counters.

module simon_ctrl_gen #(
  parameter int unsigned N_COLOURS      = 4,
  parameter int unsigned ROUND_W        = 6,
  parameter int unsigned MAX_ROUNDS     = 32,
  parameter int unsigned SPEED_EVERY    = 5,
  parameter int unsigned SPEED_W        = 3,
  parameter int unsigned FAIL_FLASHES   = 3,
  parameter int unsigned TIMEOUT_PULSES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           launch_keys,
  input  logic [N_COLOURS-1:0] player_input,
  input  logic                 pulse,
  input  logic [N_COLOURS-1:0] seq_colour,
  output logic [ROUND_W-1:0]   seq_idx,
  output logic                 load_colour,
  output logic                 load_speed,
  output logic [SPEED_W-1:0]   speed,
  output logic                 flash_en,
  output logic [N_COLOURS-1:0] flash_colour,
  output logic [ROUND_W-1:0]   current_round,
  output logic                 win,
  output logic                 lose,
  output logic                 busy
);

  // Counter widths; the timeout counter keeps one bit even when disabled.
  localparam int unsigned TO_W = (TIMEOUT_PULSES > 0) ? $clog2(TIMEOUT_PULSES + 1) : 1;
  localparam int unsigned FC_W = $clog2(FAIL_FLASHES + 1);

  localparam logic                 TO_EN      = (TIMEOUT_PULSES != 0);
  localparam logic [TO_W-1:0]      TO_LIMIT   = TO_W'(TIMEOUT_PULSES);
  localparam logic [FC_W-1:0]      FC_LIMIT   = FC_W'(FAIL_FLASHES);
  localparam logic [ROUND_W-1:0]   ROUND_LAST = ROUND_W'(MAX_ROUNDS);
  localparam logic [SPEED_W-1:0]   SPEED_MAX  = {SPEED_W{1'b1}};
  localparam logic [ROUND_W-1:0]   ROUND_ONE  = ROUND_W'(1);
  localparam logic [TO_W-1:0]      TO_ONE     = TO_W'(1);
  localparam logic [FC_W-1:0]      FC_ONE     = FC_W'(1);
  localparam logic [SPEED_W-1:0]   SPEED_ONE  = SPEED_W'(1);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ARM       = 4'd1,
    ST_RELEASE   = 4'd2,
    ST_ADD       = 4'd3,
    ST_SPEED     = 4'd4,
    ST_SHOW_WAIT = 4'd5,
    ST_SHOW_ON   = 4'd6,
    ST_SHOW_OFF  = 4'd7,
    ST_PLAYER    = 4'd8,
    ST_CHECK     = 4'd9,
    ST_DESELECT  = 4'd10,
    ST_FAIL_ON   = 4'd11,
    ST_FAIL_OFF  = 4'd12,
    ST_END       = 4'd13
  } state_t;

  state_t              state_r, state_nx;
  logic [ROUND_W-1:0]  idx_r, idx_nx;
  logic [ROUND_W-1:0]  round_r, round_nx;
  logic [SPEED_W-1:0]  speed_r, speed_nx;
  logic [TO_W-1:0]     tcnt_r, tcnt_nx;
  logic [FC_W-1:0]     fcnt_r, fcnt_nx;
  logic                win_r, win_nx;
  logic                lose_r, lose_nx;

  // True when the freshly added round starts a new speed step.
  function automatic logic speed_step_due(input logic [ROUND_W-1:0] rnd);
    logic [31:0] prev;
    prev = 32'(rnd) - 32'd1;
    speed_step_due = (rnd > ROUND_ONE) && ((prev % SPEED_EVERY) == 32'd0);
  endfunction

  // Speed level plus one, held at the top level once reached.
  function automatic logic [SPEED_W-1:0] speed_inc(input logic [SPEED_W-1:0] spd);
    if (spd == SPEED_MAX) begin
      speed_inc = spd;
    end else begin
      speed_inc = spd + SPEED_ONE;
    end
  endfunction

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      round_r <= '0;
      speed_r <= '0;
      tcnt_r  <= '0;
      fcnt_r  <= '0;
      win_r   <= 1'b0;
      lose_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      idx_r   <= idx_nx;
      round_r <= round_nx;
      speed_r <= speed_nx;
      tcnt_r  <= tcnt_nx;
      fcnt_r  <= fcnt_nx;
      win_r   <= win_nx;
      lose_r  <= lose_nx;
    end
  end

  // Next-state and counter update logic; round and speed change on entry to ADD/SPEED.
  always_comb begin
    state_nx = state_r;
    idx_nx   = idx_r;
    round_nx = round_r;
    speed_nx = speed_r;
    tcnt_nx  = tcnt_r;
    fcnt_nx  = fcnt_r;
    win_nx   = win_r;
    lose_nx  = lose_r;

    case (state_r)
      ST_IDLE: begin
        idx_nx   = '0;
        round_nx = '0;
        speed_nx = '0;
        tcnt_nx  = '0;
        fcnt_nx  = '0;
        win_nx   = 1'b0;
        lose_nx  = 1'b0;
        if (launch_keys[0]) begin
          state_nx = ST_ARM;
        end else begin
          state_nx = ST_IDLE;
        end
      end

      ST_ARM: begin
        if (launch_keys == 2'b11) begin
          state_nx = ST_RELEASE;
        end else begin
          state_nx = ST_ARM;
        end
      end

      ST_RELEASE: begin
        if (launch_keys == 2'b00) begin
          state_nx = ST_ADD;
          round_nx = round_r + ROUND_ONE;
        end else begin
          state_nx = ST_RELEASE;
        end
      end

      ST_ADD: begin
        idx_nx = '0;
        if (speed_step_due(round_r)) begin
          state_nx = ST_SPEED;
          speed_nx = speed_inc(speed_r);
        end else begin
          state_nx = ST_SHOW_WAIT;
        end
      end

      ST_SPEED: begin
        state_nx = ST_SHOW_WAIT;
      end

      ST_SHOW_WAIT: begin
        if (pulse) begin
          if (idx_r == round_r) begin
            state_nx = ST_PLAYER;
            idx_nx   = '0;
            tcnt_nx  = '0;
          end else begin
            state_nx = ST_SHOW_ON;
          end
        end else begin
          state_nx = ST_SHOW_WAIT;
        end
      end

      ST_SHOW_ON: begin
        if (pulse) begin
          state_nx = ST_SHOW_OFF;
        end else begin
          state_nx = ST_SHOW_ON;
        end
      end

      ST_SHOW_OFF: begin
        idx_nx   = idx_r + ROUND_ONE;
        state_nx = ST_SHOW_WAIT;
      end

      ST_PLAYER: begin
        if (idx_r == round_r) begin
          if (round_r == ROUND_LAST) begin
            state_nx = ST_END;
            win_nx   = 1'b1;
          end else begin
            state_nx = ST_ADD;
            round_nx = round_r + ROUND_ONE;
          end
        end else if (player_input != '0) begin
          // A button press wins over a timeout pulse in the same cycle.
          state_nx = ST_CHECK;
        end else if (TO_EN && pulse) begin
          if ((tcnt_r + TO_ONE) == TO_LIMIT) begin
            state_nx = ST_FAIL_ON;
            round_nx = round_r - ROUND_ONE;
            fcnt_nx  = '0;
          end else begin
            state_nx = ST_PLAYER;
            tcnt_nx  = tcnt_r + TO_ONE;
          end
        end else begin
          state_nx = ST_PLAYER;
        end
      end

      ST_CHECK: begin
        // Exact match only: a multi-press never equals a one-hot colour.
        if (player_input == seq_colour) begin
          state_nx = ST_DESELECT;
        end else begin
          state_nx = ST_FAIL_ON;
          round_nx = round_r - ROUND_ONE;
          fcnt_nx  = '0;
        end
      end

      ST_DESELECT: begin
        if (player_input == '0) begin
          state_nx = ST_PLAYER;
          idx_nx   = idx_r + ROUND_ONE;
          tcnt_nx  = '0;
        end else begin
          state_nx = ST_DESELECT;
        end
      end

      ST_FAIL_ON: begin
        if (pulse) begin
          state_nx = ST_FAIL_OFF;
          fcnt_nx  = fcnt_r + FC_ONE;
        end else begin
          state_nx = ST_FAIL_ON;
        end
      end

      ST_FAIL_OFF: begin
        if (pulse) begin
          if (fcnt_r == FC_LIMIT) begin
            state_nx = ST_END;
            lose_nx  = 1'b1;
          end else begin
            state_nx = ST_FAIL_ON;
          end
        end else begin
          state_nx = ST_FAIL_OFF;
        end
      end

      ST_END: begin
        state_nx = ST_END;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from the state register and counters.
  always_comb begin
    seq_idx       = idx_r;
    load_colour   = 1'b0;
    load_speed    = 1'b0;
    flash_en      = 1'b0;
    busy          = 1'b1;
    speed         = speed_r;
    current_round = round_r;
    win           = win_r;
    lose          = lose_r;

    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_ADD: begin
        // round_r already holds the new round, so the slot written is round-1.
        seq_idx     = round_r - ROUND_ONE;
        load_colour = 1'b1;
      end
      ST_SPEED: begin
        load_speed = 1'b1;
      end
      ST_SHOW_ON: begin
        flash_en = 1'b1;
      end
      ST_FAIL_ON: begin
        flash_en = 1'b1;
      end
      ST_END: begin
        busy = 1'b0;
      end
      default: begin
        busy = 1'b1;
      end
    endcase

    if (flash_en) begin
      flash_colour = seq_colour;
    end else begin
      flash_colour = '0;
    end
  end

endmodule

// File: tb/tb_simon_ctrl_gen.sv
// tb_simon_ctrl_gen: directed bench for simon_ctrl_gen.
// Five controller instances with different parameter sets share the key,
// button and pulse inputs; only the selected one is out of reset at a time.
// The colour store is modelled as a fixed one-hot colour per index.

module tb_simon_ctrl_gen;

  logic       clk = 1'b0;
  logic [4:0] rst;
  logic [1:0] keys;
  logic [3:0] pin;
  logic       pulse;
  logic [2:0] sel;

  logic [5:0] idx_a  [5];
  logic [3:0] sc_a   [5];
  logic       lc_a   [5];
  logic       ls_a   [5];
  logic       fe_a   [5];
  logic [3:0] fc_a   [5];
  logic [5:0] rnd_a  [5];
  logic       win_a  [5];
  logic       lose_a [5];
  logic       busy_a [5];
  logic [2:0] spd0, spd1, spd3, spd4;
  logic       spd2;

  logic [5:0] m_idx;
  logic       m_load_colour, m_load_speed, m_flash_en, m_win, m_lose, m_busy;
  logic [3:0] m_flash_colour;
  logic [5:0] m_round;
  logic [2:0] m_speed;

  int n_checks = 0;
  int n_pass   = 0;
  int lc_cnt   = 0;
  int ls_cnt   = 0;

  // Bench colour store: index i holds colour 1 << (i mod 4).
  function automatic logic [3:0] colour_of(input logic [5:0] i);
    logic [1:0] k;
    k = i[1:0];
    colour_of = 4'b0001 << k;
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_store
    assign sc_a[g] = colour_of(idx_a[g]);
  end

  simon_ctrl_gen u0 (
    .clk(clk), .reset(rst[0]), .launch_keys(keys), .player_input(pin), .pulse(pulse),
    .seq_colour(sc_a[0]), .seq_idx(idx_a[0]), .load_colour(lc_a[0]), .load_speed(ls_a[0]),
    .speed(spd0), .flash_en(fe_a[0]), .flash_colour(fc_a[0]), .current_round(rnd_a[0]),
    .win(win_a[0]), .lose(lose_a[0]), .busy(busy_a[0]));

  simon_ctrl_gen #(.MAX_ROUNDS(3)) u1 (
    .clk(clk), .reset(rst[1]), .launch_keys(keys), .player_input(pin), .pulse(pulse),
    .seq_colour(sc_a[1]), .seq_idx(idx_a[1]), .load_colour(lc_a[1]), .load_speed(ls_a[1]),
    .speed(spd1), .flash_en(fe_a[1]), .flash_colour(fc_a[1]), .current_round(rnd_a[1]),
    .win(win_a[1]), .lose(lose_a[1]), .busy(busy_a[1]));

  simon_ctrl_gen #(.SPEED_EVERY(2), .SPEED_W(1), .MAX_ROUNDS(7)) u2 (
    .clk(clk), .reset(rst[2]), .launch_keys(keys), .player_input(pin), .pulse(pulse),
    .seq_colour(sc_a[2]), .seq_idx(idx_a[2]), .load_colour(lc_a[2]), .load_speed(ls_a[2]),
    .speed(spd2), .flash_en(fe_a[2]), .flash_colour(fc_a[2]), .current_round(rnd_a[2]),
    .win(win_a[2]), .lose(lose_a[2]), .busy(busy_a[2]));

  simon_ctrl_gen #(.TIMEOUT_PULSES(2)) u3 (
    .clk(clk), .reset(rst[3]), .launch_keys(keys), .player_input(pin), .pulse(pulse),
    .seq_colour(sc_a[3]), .seq_idx(idx_a[3]), .load_colour(lc_a[3]), .load_speed(ls_a[3]),
    .speed(spd3), .flash_en(fe_a[3]), .flash_colour(fc_a[3]), .current_round(rnd_a[3]),
    .win(win_a[3]), .lose(lose_a[3]), .busy(busy_a[3]));

  simon_ctrl_gen #(.TIMEOUT_PULSES(0)) u4 (
    .clk(clk), .reset(rst[4]), .launch_keys(keys), .player_input(pin), .pulse(pulse),
    .seq_colour(sc_a[4]), .seq_idx(idx_a[4]), .load_colour(lc_a[4]), .load_speed(ls_a[4]),
    .speed(spd4), .flash_en(fe_a[4]), .flash_colour(fc_a[4]), .current_round(rnd_a[4]),
    .win(win_a[4]), .lose(lose_a[4]), .busy(busy_a[4]));

  // Route the selected instance's outputs to the observation signals.
  always_comb begin
    m_idx          = idx_a[sel];
    m_load_colour  = lc_a[sel];
    m_load_speed   = ls_a[sel];
    m_flash_en     = fe_a[sel];
    m_flash_colour = fc_a[sel];
    m_round        = rnd_a[sel];
    m_win          = win_a[sel];
    m_lose         = lose_a[sel];
    m_busy         = busy_a[sel];
    case (sel)
      3'd0:    m_speed = spd0;
      3'd1:    m_speed = spd1;
      3'd2:    m_speed = {2'b00, spd2};
      3'd3:    m_speed = spd3;
      default: m_speed = spd4;
    endcase
  end

  // Count strobe cycles of the selected instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_load_colour) lc_cnt <= lc_cnt + 1;
    if (m_load_speed)  ls_cnt <= ls_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset every instance, then release only instance k.
  task automatic select(input int k);
    rst   = 5'b00000;
    keys  = 2'b00;
    pin   = 4'b0000;
    pulse = 1'b0;
    sel   = 3'(k);
    step();
    step();
    rst[k] = 1'b1;
    step();
  endtask

  // Start handshake; returns with the instance in ADD.
  task automatic start();
    keys = 2'b01; step();
    keys = 2'b11; step();
    keys = 2'b00; step();
  endtask

  // From ADD or SPEED, pulse every cycle through a show of r colours into PLAYER.
  task automatic show(input int r, output int flashes, output int colour_err, output int strobes);
    flashes = 0; colour_err = 0; strobes = 0;
    pulse = 1'b1;
    for (int s = 0; s < 3 * r + 2; s++) begin
      step();
      if (m_flash_en) begin
        if (m_flash_colour !== colour_of(6'(flashes))) colour_err++;
        flashes++;
      end
      if (m_load_colour || m_load_speed) strobes++;
    end
    pulse = 1'b0;
  endtask

  // From PLAYER at idx 0, enter r correct moves and leave PLAYER.
  task automatic play(input int r);
    for (int i = 0; i < r; i++) begin
      pin = colour_of(6'(i));
      step();
      step();
      pin = 4'b0000;
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 5'b00000; keys = 2'b00; pin = 4'b0000; pulse = 1'b0; sel = 3'd0;
    step(); step();
    n_checks++;
    if ({m_idx, m_round, m_speed, m_flash_colour} !== 19'd0)
      $display("FAIL reset_buses: got %0h expected 0", {m_idx, m_round, m_speed, m_flash_colour});
    else n_pass++;
    n_checks++;
    if ({m_load_colour, m_load_speed, m_flash_en, m_win, m_lose, m_busy} !== 6'b000000)
      $display("FAIL reset_flags: got %b expected 000000",
               {m_load_colour, m_load_speed, m_flash_en, m_win, m_lose, m_busy});
    else n_pass++;
    rst[0] = 1'b1; step();
    n_checks++;
    if (m_busy !== 1'b0) $display("FAIL idle_no_keys_busy: got %0d expected 0", m_busy);
    else n_pass++;
    keys = 2'b01; step();
    n_checks++;
    if (m_busy !== 1'b1) $display("FAIL arm_busy: got %0d expected 1", m_busy);
    else n_pass++;
  endtask

  task automatic test_start();
    int fl, ce, sb, base;
    select(0);
    base = lc_cnt;
    start();
    n_checks++;
    if ({m_load_colour, m_idx, m_round} !== {1'b1, 6'd0, 6'd1})
      $display("FAIL start_add: got lc=%0d idx=%0d round=%0d expected lc=1 idx=0 round=1",
               m_load_colour, m_idx, m_round);
    else n_pass++;
    show(1, fl, ce, sb);
    n_checks++;
    if (fl !== 1) $display("FAIL start_flash_count: got %0d expected 1", fl);
    else n_pass++;
    n_checks++;
    if ({ce, sb} !== {32'd0, 32'd0}) $display("FAIL start_show_colour_strobe: got %0d/%0d expected 0/0", ce, sb);
    else n_pass++;
    n_checks++;
    if (lc_cnt - base !== 1) $display("FAIL start_load_count: got %0d expected 1", lc_cnt - base);
    else n_pass++;
    n_checks++;
    if ({m_busy, m_flash_en, m_idx} !== {1'b1, 1'b0, 6'd0})
      $display("FAIL start_player: got busy=%0d fe=%0d idx=%0d expected 1 0 0", m_busy, m_flash_en, m_idx);
    else n_pass++;
  endtask

  task automatic test_reset_mid_show();
    int fl, ce, sb;
    select(0);
    start();
    pulse = 1'b1;
    step(); step();
    n_checks++;
    if ({m_flash_en, m_flash_colour} !== 5'b1_0001)
      $display("FAIL midshow_on: got fe=%0d fc=%b expected 1 0001", m_flash_en, m_flash_colour);
    else n_pass++;
    rst[0] = 1'b0;
    step();
    n_checks++;
    if ({m_flash_en, m_load_colour, m_busy, m_round, m_idx, m_flash_colour} !== 19'd0)
      $display("FAIL midshow_reset: got fe=%0d lc=%0d busy=%0d round=%0d idx=%0d fc=%b expected all 0",
               m_flash_en, m_load_colour, m_busy, m_round, m_idx, m_flash_colour);
    else n_pass++;
    rst[0] = 1'b1; pulse = 1'b0;
    step();
    start();
    n_checks++;
    if ({m_load_colour, m_idx, m_round} !== {1'b1, 6'd0, 6'd1})
      $display("FAIL restart_add: got lc=%0d idx=%0d round=%0d expected 1 0 1", m_load_colour, m_idx, m_round);
    else n_pass++;
    show(1, fl, ce, sb);
    n_checks++;
    if (fl !== 1) $display("FAIL restart_flash_count: got %0d expected 1", fl);
    else n_pass++;
  endtask

  task automatic test_perfect_play();
    int fl, ce, sb, total_fl, total_ce, base;
    total_fl = 0; total_ce = 0;
    select(1);
    base = lc_cnt;
    start();
    for (int r = 1; r <= 3; r++) begin
      show(r, fl, ce, sb);
      total_fl += fl; total_ce += ce;
      play(r);
      if (r < 3) begin
        n_checks++;
        if ({m_load_colour, m_round, m_idx} !== {1'b1, 6'(r + 1), 6'(r)})
          $display("FAIL perfect_add_r%0d: got lc=%0d round=%0d idx=%0d expected 1 %0d %0d",
                   r + 1, m_load_colour, m_round, m_idx, r + 1, r);
        else n_pass++;
      end
    end
    n_checks++;
    if ({m_win, m_lose, m_busy, m_round} !== {3'b100, 6'd3})
      $display("FAIL perfect_end: got win=%0d lose=%0d busy=%0d round=%0d expected 1 0 0 3",
               m_win, m_lose, m_busy, m_round);
    else n_pass++;
    n_checks++;
    if ({total_fl, total_ce} !== {32'd6, 32'd0})
      $display("FAIL perfect_flashes: got %0d (colour errs %0d) expected 6 (0)", total_fl, total_ce);
    else n_pass++;
    keys = 2'b11; step(); step(); step(); keys = 2'b01; step();
    n_checks++;
    if ({m_win, m_busy} !== 2'b10) $display("FAIL perfect_end_hold: got win=%0d busy=%0d expected 1 0", m_win, m_busy);
    else n_pass++;
    n_checks++;
    if (lc_cnt - base !== 3) $display("FAIL perfect_load_count: got %0d expected 3", lc_cnt - base);
    else n_pass++;
    keys = 2'b00;
  endtask

  task automatic test_speed_up();
    int fl, ce, sb, base;
    select(2);
    base = ls_cnt;
    start();
    for (int r = 1; r <= 7; r++) begin
      n_checks++;
      if (m_speed !== ((r > 3) ? 3'd1 : 3'd0))
        $display("FAIL speed_at_add_r%0d: got %0d expected %0d", r, m_speed, (r > 3) ? 1 : 0);
      else n_pass++;
      if (r == 3 || r == 5 || r == 7) begin
        step();
        n_checks++;
        if ({m_load_speed, m_speed} !== {1'b1, 3'd1})
          $display("FAIL speed_step_r%0d: got ls=%0d speed=%0d expected 1 1", r, m_load_speed, m_speed);
        else n_pass++;
      end
      show(r, fl, ce, sb);
      play(r);
    end
    n_checks++;
    if ({m_win, m_busy, m_speed} !== {2'b10, 3'd1})
      $display("FAIL speed_end: got win=%0d busy=%0d speed=%0d expected 1 0 1", m_win, m_busy, m_speed);
    else n_pass++;
    n_checks++;
    if (ls_cnt - base !== 3) $display("FAIL speed_load_count: got %0d expected 3", ls_cnt - base);
    else n_pass++;
  endtask

  task automatic test_wrong_press();
    int fl, ce, sb, on, cerr;
    logic prev;
    select(0);
    start();
    for (int r = 1; r <= 3; r++) begin
      show(r, fl, ce, sb);
      play(r);
    end
    n_checks++;
    if (m_round !== 6'd4) $display("FAIL wrong_round4: got %0d expected 4", m_round);
    else n_pass++;
    show(4, fl, ce, sb);
    pin = 4'b0011;
    step(); step();
    pin = 4'b0000;
    n_checks++;
    if ({m_flash_en, m_flash_colour, m_round} !== {1'b1, 4'b0001, 6'd3})
      $display("FAIL wrong_fail_on: got fe=%0d fc=%b round=%0d expected 1 0001 3", m_flash_en, m_flash_colour, m_round);
    else n_pass++;
    on = 1; cerr = 0; prev = 1'b1;
    pulse = 1'b1;
    for (int s = 0; s < 12 && m_busy; s++) begin
      step();
      if (m_flash_en && !prev) begin
        on++;
        if (m_flash_colour !== 4'b0001) cerr++;
      end
      prev = m_flash_en;
    end
    pulse = 1'b0;
    n_checks++;
    if ({on, cerr} !== {32'd3, 32'd0}) $display("FAIL wrong_flash_phases: got %0d (colour errs %0d) expected 3 (0)", on, cerr);
    else n_pass++;
    n_checks++;
    if ({m_lose, m_win, m_busy, m_flash_en, m_round} !== {4'b1000, 6'd3})
      $display("FAIL wrong_end: got lose=%0d win=%0d busy=%0d fe=%0d round=%0d expected 1 0 0 0 3",
               m_lose, m_win, m_busy, m_flash_en, m_round);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int fl, ce, sb;
    select(3);
    start();
    show(1, fl, ce, sb);
    step(); step();
    pulse = 1'b1; step(); pulse = 1'b0;
    n_checks++;
    if ({m_flash_en, m_busy} !== 2'b01) $display("FAIL timeout_first_pulse: got fe=%0d busy=%0d expected 0 1", m_flash_en, m_busy);
    else n_pass++;
    step();
    pulse = 1'b1; step(); pulse = 1'b0;
    n_checks++;
    if ({m_flash_en, m_flash_colour, m_round} !== {1'b1, 4'b0001, 6'd0})
      $display("FAIL timeout_fail_on: got fe=%0d fc=%b round=%0d expected 1 0001 0", m_flash_en, m_flash_colour, m_round);
    else n_pass++;
    // Press and final timeout pulse together: the press must win.
    select(3);
    start();
    show(1, fl, ce, sb);
    pulse = 1'b1; step();
    pin = 4'b0001; step();
    pulse = 1'b0; step();
    n_checks++;
    if ({m_flash_en, m_busy, m_round} !== {2'b01, 6'd1})
      $display("FAIL press_beats_timeout: got fe=%0d busy=%0d round=%0d expected 0 1 1", m_flash_en, m_busy, m_round);
    else n_pass++;
    step(); step(); step(); step();
    n_checks++;
    if ({m_load_colour, m_round} !== {1'b0, 6'd1})
      $display("FAIL held_button_waits: got lc=%0d round=%0d expected 0 1", m_load_colour, m_round);
    else n_pass++;
    pin = 4'b0000; step(); step();
    n_checks++;
    if ({m_load_colour, m_round} !== {1'b1, 6'd2})
      $display("FAIL release_next_round: got lc=%0d round=%0d expected 1 2", m_load_colour, m_round);
    else n_pass++;
  endtask

  task automatic test_no_timeout();
    int fl, ce, sb, bad;
    select(4);
    start();
    show(1, fl, ce, sb);
    bad = 0;
    pulse = 1'b1;
    for (int s = 0; s < 20; s++) begin
      step();
      if (m_flash_en || !m_busy) bad++;
    end
    pulse = 1'b0;
    n_checks++;
    if (bad !== 0) $display("FAIL no_timeout_stays: got %0d bad cycles expected 0", bad);
    else n_pass++;
    play(1);
    n_checks++;
    if ({m_load_colour, m_round} !== {1'b1, 6'd2})
      $display("FAIL no_timeout_still_player: got lc=%0d round=%0d expected 1 2", m_load_colour, m_round);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_reset_mid_show();
    test_perfect_play();
    test_speed_up();
    test_wrong_press();
    test_timeout();
    test_no_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simon_ctrl_gen.md
# simon_ctrl_gen

Parametrised game controller for the Simon Says design: sequences start handshake, round growth, sequence playback, player checking, per-move timeout and the failure flash. It sits between the launch keys/player buttons and the colour-sequence store, pulse-rate generator and display driver. It generalises the original 4-colour/32-round controller to N colours, a configurable round limit, speed-up interval and flash count. It adds a per-move timeout, explicit win/lose flags and speed saturation.

## Interface
- N_COLOURS, 4: number of buttons/colours; all colour buses are one-hot of this width
- ROUND_W, 6: width of round and index counters
- MAX_ROUNDS, 32: rounds to win; must be 1..2^ROUND_W-1
- SPEED_EVERY, 5: rounds per speed step; must be ≥1
- SPEED_W, 3: speed level width
- FAIL_FLASHES, 3: failure flashes; must be ≥1
- TIMEOUT_PULSES, 8: pulses allowed per move; 0 disables the timeout
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-low; low at a rising edge forces reset state
- launch_keys  in  2  start keys, active-high
- player_input  in  N_COLOURS  player buttons, active-high
- pulse  in  1  one-cycle strobe from the rate generator
- seq_colour  in  N_COLOURS  stored colour at seq_idx; combinational read, valid same cycle
- seq_idx  out  ROUND_W  sequence index being written, shown or checked
- load_colour  out  1  strobe: store a new random colour at seq_idx
- load_speed  out  1  strobe: speed changed
- speed  out  SPEED_W  current speed level
- flash_en  out  1  display colour flash_colour
- flash_colour  out  N_COLOURS  colour to display; 0 when flash_en=0
- current_round  out  ROUND_W  rounds reached (after a loss, rounds passed)
- win, lose  out  1  sticky end flags
- busy  out  1  high in every state except IDLE and END

## Operation
- States: IDLE, ARM, RELEASE, ADD, SPEED, SHOW_WAIT, SHOW_ON, SHOW_OFF, PLAYER, CHECK, DESELECT, FAIL_ON, FAIL_OFF, END.
- IDLE: clears round, speed, idx, fail count and flags. Moves to ARM when launch_keys[0]=1.
- ARM: moves to RELEASE when launch_keys==2'b11.
- RELEASE: moves to ADD when launch_keys==0.
- ADD: current_round+1. seq_idx=new round-1. load_colour=1 for one cycle. Moves to SPEED if new round>1 and (new round-1)%SPEED_EVERY==0, else to SHOW_WAIT. idx←0.
- SPEED: speed+1, saturating at 2^SPEED_W-1. load_speed=1 for one cycle, even when saturated. Moves to SHOW_WAIT.
- SHOW_WAIT: on pulse, moves to PLAYER if idx==current_round (idx←0, timeout counter←0), else to SHOW_ON.
- SHOW_ON: flash_en=1, flash_colour=seq_colour. On pulse, moves to SHOW_OFF.
- SHOW_OFF: idx+1, then SHOW_WAIT.
- PLAYER:
  - if idx==current_round: END with win=1 when current_round==MAX_ROUNDS, else ADD.
  - else if player_input≠0: CHECK.
  - else if TIMEOUT_PULSES≠0 and a pulse brings the timeout count to TIMEOUT_PULSES: FAIL_ON.
- CHECK: correct only if player_input==seq_colour exactly. Multi-press and wrong colour both fail. Correct moves to DESELECT; wrong moves to FAIL_ON.
- DESELECT: waits for player_input==0, then idx+1, timeout counter←0, and PLAYER.
- Failure:
  - On the first FAIL_ON entry, current_round←current_round-1 and the fail count clears.
  - FAIL_ON: flash_en=1, flash_colour=seq_colour at the failing idx. On pulse, fail count+1 and FAIL_OFF.
  - FAIL_OFF: flash_en=0. On pulse, END with lose=1 if fail count==FAIL_FLASHES, else FAIL_ON.
- END: holds until reset; launch_keys are ignored. win and lose are never both 1.
- seq_idx=idx in every state except ADD.

## Timing
- Reset values: state IDLE; seq_idx, speed, current_round, flash_colour all 0; load_colour, load_speed, flash_en, win, lose, busy all 0.
- Outputs are Moore, decoded from the state register plus counters. They change one cycle after the transition edge.
- Strobes last exactly one cycle per state visit.
- A pulse is consumed by at most one transition. A pulse in the cycle of entering a waiting state counts.
- Simultaneous events in PLAYER: player_input≠0 takes priority over a timeout pulse.
- Reset low in any state, mid-flash included, gives reset state at the next edge. No stale strobe follows.
- A held button after the last correct move never re-enters CHECK; DESELECT must see all buttons released first.
- idx and counters never wrap: idx ≤ MAX_ROUNDS < 2^ROUND_W.

## Test plan
All scenarios use the defaults unless stated.
- Start handshake: launch_keys 01→11→00 → exactly one load_colour, seq_idx=0, current_round=1, then a single flash of seq_colour.
- Perfect play with MAX_ROUNDS=3: correct inputs each round → 3 load_colour strobes, 1+2+3 show flashes, then END with win=1, current_round=3, busy=0.
- Speed-up with SPEED_EVERY=2, SPEED_W=1, MAX_ROUNDS=7: correct play → load_speed at rounds 3, 5 and 7; speed=1 from round 3 on, saturated.
- Wrong press in round 4: the move is 4'b0011 against seq_colour 4'b0001 → 3 flash_en on-phases of 4'b0001, then lose=1, current_round=3.
- Timeout with TIMEOUT_PULSES=2: no input in PLAYER → FAIL_ON after the 2nd pulse. Repeat with TIMEOUT_PULSES=0 → stays in PLAYER indefinitely.
- Reset asserted mid-SHOW_ON, then released → flash_en=0 next cycle, all outputs at reset values; a new start behaves like the first scenario.
